// File: rtl/param_adder_accumulator.sv
// param_adder_accumulator: debounced push-button adder/accumulator with sticky overflow, op counter and display mux
// Each button is synchronised, debounced and reduced to one pulse per accepted press.

module param_adder_accumulator_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic MCLK,
    input  logic rst_n,
    input  logic raw,
    output logic pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic s1, s2;
    // The synchroniser is reset too, so a button held through reset looks like a fresh press
    always_ff @(posedge MCLK) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            state <= IDLE;
            cnt <= '0;
            pulse <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            pulse <= 1'b0;
            case (state)
                IDLE: if (s2) begin
                    cnt <= CW'(1);
                    pulse <= (DEBOUNCE_CYCLES == 1);
                    state <= (DEBOUNCE_CYCLES == 1) ? HELD : PRESS_WAIT;
                end
                PRESS_WAIT: if (!s2) begin
                    cnt <= '0;
                    state <= IDLE;
                end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    cnt <= '0;
                    pulse <= 1'b1;
                    state <= HELD;
                end else cnt <= cnt + CW'(1);
                HELD: if (!s2) begin
                    cnt <= CW'(1);
                    state <= (DEBOUNCE_CYCLES == 1) ? IDLE : RELEASE_WAIT;
                end
                RELEASE_WAIT: if (s2) begin
                    cnt <= '0;
                    state <= HELD;
                end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    cnt <= '0;
                    state <= IDLE;
                end else cnt <= cnt + CW'(1);
                default: state <= IDLE;
            endcase
        end
    end
endmodule

module param_adder_accumulator #(
    parameter int DATA_W = 8,
    parameter int WIDTH = 16,
    parameter int CNT_W = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              MCLK,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              load_btn,
    input  logic              add_btn,
    input  logic              sub_btn,
    input  logic [1:0]        sel,
    output logic [WIDTH-1:0]  acc,
    output logic [WIDTH-1:0]  operand,
    output logic [CNT_W-1:0]  op_count,
    output logic              ovf,
    output logic [WIDTH-1:0]  disp_val
);
    logic load_p, add_p, sub_p;
    logic [WIDTH:0] sum, diff;
    logic [WIDTH-1:0] disp_nxt;

    param_adder_accumulator_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load (
        .MCLK(MCLK), .rst_n(rst_n), .raw(load_btn), .pulse(load_p)
    );
    param_adder_accumulator_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_add (
        .MCLK(MCLK), .rst_n(rst_n), .raw(add_btn), .pulse(add_p)
    );
    param_adder_accumulator_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sub (
        .MCLK(MCLK), .rst_n(rst_n), .raw(sub_btn), .pulse(sub_p)
    );

    // The extra top bit is carry-out for add and borrow for sub
    always_comb begin
        sum = {1'b0, acc} + {1'b0, operand};
        diff = {1'b0, acc} - {1'b0, operand};
        disp_nxt = (sel == 2'd0) ? operand :
                   (sel == 2'd1) ? acc :
                   (sel == 2'd2) ? WIDTH'(op_count) : WIDTH'(ovf);
    end

    always_ff @(posedge MCLK) begin
        if (!rst_n) begin
            acc <= '0;
            operand <= '0;
            op_count <= '0;
            ovf <= 1'b0;
            disp_val <= '0;
        end else begin
            if (load_p) operand <= WIDTH'(din);
            else if (add_p) begin
                acc <= sum[WIDTH-1:0];
                ovf <= ovf | sum[WIDTH];
                op_count <= op_count + CNT_W'(1);
            end else if (sub_p) begin
                acc <= diff[WIDTH-1:0];
                ovf <= ovf | diff[WIDTH];
                op_count <= op_count + CNT_W'(1);
            end
            disp_val <= disp_nxt;
        end
    end
endmodule

// File: tb/tb_param_adder_accumulator.sv
// tb_param_adder_accumulator: scoreboard bench; stimulus queues expected state, a negedge monitor pops and compares
module tb_param_adder_accumulator;
    logic MCLK = 1'b0;
    logic rst_n;
    logic [7:0] din;
    logic load_btn, add_btn, sub_btn;
    logic [1:0] sel;
    logic [15:0] acc, operand, disp_val;
    logic [7:0] op_count;
    logic ovf;

    param_adder_accumulator dut (
        .MCLK(MCLK), .rst_n(rst_n), .din(din), .load_btn(load_btn), .add_btn(add_btn),
        .sub_btn(sub_btn), .sel(sel), .acc(acc), .operand(operand), .op_count(op_count),
        .ovf(ovf), .disp_val(disp_val)
    );

    always #5 MCLK = ~MCLK;

    typedef struct {
        int due;
        string tag;
        logic [15:0] acc;
        logic [15:0] operand;
        logic [7:0] cnt;
        logic ovf;
        bit dchk;
        logic [15:0] disp;
    } exp_t;

    exp_t q[$];
    exp_t cur, m;
    int cyc = 0;
    int passed = 0;
    int total = 0;

    always @(posedge MCLK) cyc <= cyc + 1;

    always @(negedge MCLK) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            m = q.pop_front();
            total++;
            if (acc === m.acc && operand === m.operand && op_count === m.cnt && ovf === m.ovf &&
                (!m.dchk || disp_val === m.disp))
                passed++;
            else
                $display("FAIL %s @%0d: got acc=%h operand=%h op_count=%h ovf=%b disp=%h, want acc=%h operand=%h op_count=%h ovf=%b disp=%h(chk=%0b)",
                         m.tag, cyc, acc, operand, op_count, ovf, disp_val,
                         m.acc, m.operand, m.cnt, m.ovf, m.disp, m.dchk);
        end
    end

    function automatic exp_t mk(logic [15:0] a, logic [15:0] o, logic [7:0] c, logic v);
        exp_t e;
        e.due = 0;
        e.tag = "";
        e.acc = a;
        e.operand = o;
        e.cnt = c;
        e.ovf = v;
        e.dchk = 1'b0;
        e.disp = '0;
        return e;
    endfunction

    task automatic push(int d, string tag);
        exp_t e = cur;
        e.due = cyc + d;
        e.tag = tag;
        q.push_back(e);
    endtask

    task automatic step(int n);
        repeat (n) @(posedge MCLK);
        #1;
    endtask

    task automatic press(logic [2:0] b, int hold, int gap, exp_t nxt, string tag);
        {load_btn, add_btn, sub_btn} = b;
        push(6, {tag, "_early"});
        cur = nxt;
        push(7, tag);
        step(hold);
        {load_btn, add_btn, sub_btn} = 3'b000;
        step(gap);
    endtask

    task automatic disp_chk(logic [1:0] s, logic [15:0] v, string tag);
        sel = s;
        push(0, {tag, "_early"});
        cur.disp = v;
        push(1, tag);
        step(2);
    endtask

    initial begin
        din = 8'h07;
        sel = 2'd0;
        rst_n = 1'b0;
        {load_btn, add_btn, sub_btn} = 3'b111;
        cur = mk(16'h0, 16'h0, 8'h0, 1'b0);
        cur.dchk = 1'b1;
        push(1, "reset");
        step(2);
        rst_n = 1'b1;
        cur.dchk = 1'b0;
        push(6, "rst_load_early");
        cur.operand = 16'h0007;
        push(7, "rst_load");
        push(12, "rst_no_add_sub");
        step(14);
        {load_btn, add_btn, sub_btn} = 3'b000;
        step(10);

        din = 8'h02;
        press(3'b100, 8, 8, mk(16'h0000, 16'h0002, 8'd0, 1'b0), "load2");
        press(3'b010, 8, 8, mk(16'h0002, 16'h0002, 8'd1, 1'b0), "add1");
        press(3'b010, 8, 8, mk(16'h0004, 16'h0002, 8'd2, 1'b0), "add2");

        add_btn = 1'b1;
        step(3);
        add_btn = 1'b0;
        push(10, "glitch_reject");
        step(12);

        add_btn = 1'b1;
        push(6, "bounce_early");
        cur = mk(16'h0006, 16'h0002, 8'd3, 1'b0);
        push(7, "bounce_add");
        step(8);
        for (int i = 0; i < 6; i++) begin
            add_btn = i[0];
            step(1);
        end
        add_btn = 1'b0;
        step(10);
        push(1, "bounce_once");
        step(2);

        din = 8'h07;
        press(3'b100, 8, 8, mk(16'h0006, 16'h0007, 8'd3, 1'b0), "load7");
        press(3'b001, 8, 8, mk(16'hFFFF, 16'h0007, 8'd4, 1'b1), "borrow");
        press(3'b010, 8, 8, mk(16'h0006, 16'h0007, 8'd5, 1'b1), "add_sticky");

        cur.dchk = 1'b1;
        cur.disp = 16'h0007;
        disp_chk(2'd3, 16'h0001, "disp_ovf_pre");
        disp_chk(2'd0, 16'h0007, "disp_operand");
        disp_chk(2'd1, 16'h0006, "disp_acc");
        disp_chk(2'd2, 16'h0005, "disp_count");
        disp_chk(2'd3, 16'h0001, "disp_ovf");
        sel = 2'd0;
        cur.dchk = 1'b0;
        step(2);

        din = 8'h09;
        {load_btn, add_btn} = 2'b11;
        push(6, "simul_early");
        cur.operand = 16'h0009;
        push(7, "simul_load_wins");
        push(16, "simul_no_add");
        step(20);
        {load_btn, add_btn} = 2'b00;
        step(10);

        rst_n = 1'b0;
        cur = mk(16'h0, 16'h0, 8'h0, 1'b0);
        push(2, "reset2");
        step(3);
        rst_n = 1'b1;
        din = 8'hFF;
        press(3'b100, 8, 8, mk(16'h0000, 16'h00FF, 8'd0, 1'b0), "loadFF");
        for (int i = 1; i <= 258; i++)
            press(3'b010, 6, 6, mk(16'(255 * i), 16'h00FF, 8'(i), (255 * i) > 65535), "add_loop");
        step(3);

        total++;
        if (operand === 16'h00FF) passed++;
        else $display("FAIL final_operand: got %h want 00ff", operand);
        total++;
        if (acc === 16'h00FE) passed++;
        else $display("FAIL final_acc: got %h want 00fe", acc);
        total++;
        if (op_count === 8'd2) passed++;
        else $display("FAIL final_count: got %h want 02", op_count);
        total++;
        if (ovf === 1'b1) passed++;
        else $display("FAIL final_ovf: got %b want 1", ovf);

        while (q.size() > 0) begin
            m = q.pop_front();
            total++;
            $display("FAIL %s: never checked, due at cycle %0d", m.tag, m.due);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
